// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: operand-mux
// select codes, load-wait FSM states and the hardwired-zero register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN   = 1'b0,
    LWAIT = 1'b1
  } hz_state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_sel_unit.sv
// Priority forwarding select for one EXE operand: the youngest producer (MEM)
// wins over WB; register 0 is never forwarded.
module fwd_sel_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              en_i,
  input  logic [REG_AW-1:0] src_i,
  input  logic [REG_AW-1:0] mem_dest_i,
  input  logic              mem_wb_en_i,
  input  logic [REG_AW-1:0] wb_dest_i,
  input  logic              wb_wb_en_i,
  output fwd_sel_t          sel_o
);

  logic src_nz;
  logic mem_hit;
  logic wb_hit;

  assign src_nz  = (src_i != REG_AW'(REG_ZERO));
  assign mem_hit = mem_wb_en_i & (mem_dest_i == src_i) & src_nz;
  assign wb_hit  = wb_wb_en_i & (wb_dest_i == src_i) & src_nz;

  always_comb begin
    sel_o = FWD_REG;
    if (en_i) begin
      if (mem_hit)     sel_o = FWD_MEM;
      else if (wb_hit) sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Unified hazard/forwarding controller for the 5-stage pipeline.
// Optional stall statistics are compiled in with `define HAZARD_STAT_EN.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fwd_en,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_use_src2,
  input  logic [REG_AW-1:0] ex_src1,
  input  logic [REG_AW-1:0] ex_src2,
  input  logic              ex_use_src2,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_wb_en,
  input  logic              ex_mem_r_en,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic              mem_mem_r_en,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              wb_wb_en,
  input  logic              br_taken,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic [1:0]        sel_st,
  output logic              if_id_hold,
  output logic              id_ex_bubble,
  output logic              ex_wb_hold,
  output logic              flush,
  output logic [CNT_W-1:0]  stat_stall,
  output logic [CNT_W-1:0]  stat_hold,
  output logic [CNT_W-1:0]  stat_flush,
  output hz_state_t         dbg_state
);

  localparam logic [3:0] LAT_LAST  = 4'(MEM_LAT - 1);
  localparam bit         LAT_MULTI = (MEM_LAT > 1);

  function automatic logic reg_match(input logic en, input logic [REG_AW-1:0] dest,
                                     input logic [REG_AW-1:0] src);
    return en & (dest == src) & (src != REG_AW'(REG_ZERO));
  endfunction

  // Forwarding selects; disabled (all FWD_REG) when forwarding is off or in reset.
  fwd_sel_t sel_a_w, sel_b_w, sel_st_w;
  logic     fwd_on;

  assign fwd_on = fwd_en & ~rst;

  fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .en_i(fwd_on), .src_i(ex_src1), .mem_dest_i(mem_dest), .mem_wb_en_i(mem_wb_en),
    .wb_dest_i(wb_dest), .wb_wb_en_i(wb_wb_en), .sel_o(sel_a_w)
  );
  fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .en_i(fwd_on & ex_use_src2), .src_i(ex_src2), .mem_dest_i(mem_dest), .mem_wb_en_i(mem_wb_en),
    .wb_dest_i(wb_dest), .wb_wb_en_i(wb_wb_en), .sel_o(sel_b_w)
  );
  fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_st (
    .en_i(fwd_on), .src_i(ex_src2), .mem_dest_i(mem_dest), .mem_wb_en_i(mem_wb_en),
    .wb_dest_i(wb_dest), .wb_wb_en_i(wb_wb_en), .sel_o(sel_st_w)
  );

  assign sel_a  = sel_a_w;
  assign sel_b  = sel_b_w;
  assign sel_st = sel_st_w;

  // RAW detection against the ID instruction's used sources.
  logic raw_ex, raw_mem, raw;

  always_comb begin
    raw_ex  = reg_match(ex_wb_en, ex_dest, id_src1) |
              (id_use_src2 & reg_match(ex_wb_en, ex_dest, id_src2));
    raw_mem = reg_match(mem_wb_en, mem_dest, id_src1) |
              (id_use_src2 & reg_match(mem_wb_en, mem_dest, id_src2));
    raw     = fwd_en ? (ex_mem_r_en & raw_ex) : (raw_ex | raw_mem);
  end

  // Multi-cycle load FSM: the RUN cycle that sees the load counts as wait cycle 0.
  hz_state_t  state_q, state_d;
  logic [3:0] lat_cnt_q, lat_cnt_d;
  logic       hold_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      lat_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    hold_raw  = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_mem_r_en && LAT_MULTI) begin
          hold_raw  = 1'b1;
          lat_cnt_d = 4'd1;
          state_d   = LWAIT;
        end
      end
      LWAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          lat_cnt_d = 4'd0;
          state_d   = RUN;
        end else begin
          hold_raw  = 1'b1;
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign dbg_state = state_q;

  // A held branch defers its flush; a flush kills rather than stalls the dependent.
  logic raw_g;

  assign ex_wb_hold   = hold_raw & ~rst;
  assign raw_g        = raw & ~rst;
  assign flush        = br_taken & ~ex_wb_hold & ~rst;
  assign if_id_hold   = (raw_g | ex_wb_hold) & ~flush;
  assign id_ex_bubble = raw_g & ~ex_wb_hold & ~flush;

`ifdef HAZARD_STAT_EN
  logic [CNT_W-1:0] stall_cnt_q, hold_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      hold_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (id_ex_bubble && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ex_wb_hold && (hold_cnt_q != '1))    hold_cnt_q  <= hold_cnt_q + 1'b1;
      if (flush && (flush_cnt_q != '1))        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stat_stall = stall_cnt_q;
  assign stat_hold  = hold_cnt_q;
  assign stat_flush = flush_cnt_q;
`else
  assign stat_stall = '0;
  assign stat_hold  = '0;
  assign stat_flush = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a MEM_LAT=4 and a MEM_LAT=1 instance share
// stimulus; directed cases then random cycles against a window-based model.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  localparam int AW   = 5;
  localparam int CW   = 16;
  localparam int LAT4 = 4;
  localparam int LAT1 = 1;

  // Clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Inputs
  logic          fwd_en, id_use_src2, ex_use_src2;
  logic [AW-1:0] id_src1, id_src2, ex_src1, ex_src2, ex_dest, mem_dest, wb_dest;
  logic          ex_wb_en, ex_mem_r_en, mem_wb_en, mem_mem_r_en, wb_wb_en, br_taken;

  // Outputs, MEM_LAT=4 instance
  logic [1:0]    sel_a, sel_b, sel_st;
  logic          if_id_hold, id_ex_bubble, ex_wb_hold, flush;
  logic [CW-1:0] stat_stall, stat_hold, stat_flush;
  hz_state_t     dbg_state;

  // Outputs, MEM_LAT=1 instance
  logic [1:0]    sel_a_1, sel_b_1, sel_st_1;
  logic          if_id_hold_1, id_ex_bubble_1, ex_wb_hold_1, flush_1;
  logic [CW-1:0] stat_stall_1, stat_hold_1, stat_flush_1;
  hz_state_t     dbg_state_1;

  pipeline_hazard_ctrl #(.REG_AW(AW), .MEM_LAT(LAT4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en),
    .id_src1(id_src1), .id_src2(id_src2), .id_use_src2(id_use_src2),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_use_src2(ex_use_src2),
    .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_mem_r_en(mem_mem_r_en),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .br_taken(br_taken),
    .sel_a(sel_a), .sel_b(sel_b), .sel_st(sel_st),
    .if_id_hold(if_id_hold), .id_ex_bubble(id_ex_bubble), .ex_wb_hold(ex_wb_hold), .flush(flush),
    .stat_stall(stat_stall), .stat_hold(stat_hold), .stat_flush(stat_flush),
    .dbg_state(dbg_state)
  );

  pipeline_hazard_ctrl #(.REG_AW(AW), .MEM_LAT(LAT1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst(rst), .fwd_en(fwd_en),
    .id_src1(id_src1), .id_src2(id_src2), .id_use_src2(id_use_src2),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_use_src2(ex_use_src2),
    .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_mem_r_en(mem_mem_r_en),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .br_taken(br_taken),
    .sel_a(sel_a_1), .sel_b(sel_b_1), .sel_st(sel_st_1),
    .if_id_hold(if_id_hold_1), .id_ex_bubble(id_ex_bubble_1), .ex_wb_hold(ex_wb_hold_1),
    .flush(flush_1),
    .stat_stall(stat_stall_1), .stat_hold(stat_hold_1), .stat_flush(stat_flush_1),
    .dbg_state(dbg_state_1)
  );

  // Scoreboard counters and reference-model state
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ws4 = 0, we4 = -1, ws1 = 0, we1 = -1;   // load wait window [ws, we] in cycles
  int st_stall = 0, st_hold = 0, st_flush = 0;
  bit e_bub4, e_hold4, e_fl4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit hit(input logic en, input logic [AW-1:0] d, input logic [AW-1:0] s);
    return (en === 1'b1) && (d == s) && (s != 0);
  endfunction

  function automatic logic [1:0] exp_sel(input logic [AW-1:0] s, input logic use_it);
    if (rst || !fwd_en || !use_it) return 2'b00;
    if (hit(mem_wb_en, mem_dest, s)) return 2'b01;
    if (hit(wb_wb_en, wb_dest, s))   return 2'b10;
    return 2'b00;
  endfunction

  // A load seen while idle opens a window of lat cycles; hold covers all but the last.
  task automatic model_hold(input int lat, inout int ws, inout int we, output bit h, output bit lw);
    h  = 1'b0;
    lw = 1'b0;
    if (rst) return;
    if (!(cyc >= ws && cyc <= we) && mem_mem_r_en && lat > 1) begin
      ws = cyc;
      we = cyc + lat - 1;
    end
    h  = (cyc >= ws) && (cyc < we);
    lw = (cyc > ws) && (cyc <= we);
  endtask

  task automatic check_model();
    bit h4, h1, lw4, lw1, ex_hit, mem_hit, raw, fl4, fl1;
    int cmax;
    cmax = (1 << CW) - 1;
    model_hold(LAT4, ws4, we4, h4, lw4);
    model_hold(LAT1, ws1, we1, h1, lw1);
    ex_hit  = hit(ex_wb_en, ex_dest, id_src1) || (id_use_src2 && hit(ex_wb_en, ex_dest, id_src2));
    mem_hit = hit(mem_wb_en, mem_dest, id_src1) || (id_use_src2 && hit(mem_wb_en, mem_dest, id_src2));
    raw = !rst && (fwd_en ? (ex_mem_r_en && ex_hit) : (ex_hit || mem_hit));
    fl4 = !rst && br_taken && !h4;
    fl1 = !rst && br_taken && !h1;
    chk("sel_a", sel_a, exp_sel(ex_src1, 1'b1));
    chk("sel_b", sel_b, exp_sel(ex_src2, ex_use_src2));
    chk("sel_st", sel_st, exp_sel(ex_src2, 1'b1));
    chk("if_id_hold", if_id_hold, (raw || h4) && !fl4);
    chk("id_ex_bubble", id_ex_bubble, raw && !h4 && !fl4);
    chk("ex_wb_hold", ex_wb_hold, h4);
    chk("flush", flush, fl4);
    chk("state", dbg_state, lw4 ? LWAIT : RUN);
    chk("l1_sel_a", sel_a_1, exp_sel(ex_src1, 1'b1));
    chk("l1_if_id_hold", if_id_hold_1, (raw || h1) && !fl1);
    chk("l1_id_ex_bubble", id_ex_bubble_1, raw && !h1 && !fl1);
    chk("l1_ex_wb_hold", ex_wb_hold_1, h1);
    chk("l1_flush", flush_1, fl1);
`ifdef HAZARD_STAT_EN
    chk("stat_stall", stat_stall, rst ? 0 : st_stall);
    chk("stat_hold", stat_hold, rst ? 0 : st_hold);
    chk("stat_flush", stat_flush, rst ? 0 : st_flush);
`else
    chk("stat_stall", stat_stall, 0);
    chk("stat_hold", stat_hold, 0);
    chk("stat_flush", stat_flush, 0);
`endif
    e_bub4  = raw && !h4 && !fl4;
    e_hold4 = h4;
    e_fl4   = fl4;
    if (cmax < 0) cmax = 0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      ws4 = 0; we4 = -1; ws1 = 0; we1 = -1;
      st_stall = 0; st_hold = 0; st_flush = 0;
    end else begin
      if (e_bub4  && st_stall < (1 << CW) - 1) st_stall++;
      if (e_hold4 && st_hold  < (1 << CW) - 1) st_hold++;
      if (e_fl4   && st_flush < (1 << CW) - 1) st_flush++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    check_model();
    advance();
  endtask

  // Driver tasks
  task automatic clear_inputs();
    fwd_en = 1'b1; id_use_src2 = 1'b0; ex_use_src2 = 1'b0;
    id_src1 = '0; id_src2 = '0; ex_src1 = '0; ex_src2 = '0;
    ex_dest = '0; mem_dest = '0; wb_dest = '0;
    ex_wb_en = 1'b0; ex_mem_r_en = 1'b0; mem_wb_en = 1'b0; mem_mem_r_en = 1'b0;
    wb_wb_en = 1'b0; br_taken = 1'b0;
  endtask

  task automatic drive_random();
    fwd_en       = ($urandom_range(0, 3) != 0);
    id_src1      = AW'($urandom_range(0, 7));
    id_src2      = AW'($urandom_range(0, 7));
    id_use_src2  = $urandom_range(0, 1) != 0;
    ex_src1      = AW'($urandom_range(0, 7));
    ex_src2      = AW'($urandom_range(0, 7));
    ex_use_src2  = $urandom_range(0, 1) != 0;
    ex_dest      = AW'($urandom_range(0, 7));
    ex_wb_en     = $urandom_range(0, 1) != 0;
    ex_mem_r_en  = $urandom_range(0, 2) == 0;
    mem_dest     = AW'($urandom_range(0, 7));
    mem_wb_en    = $urandom_range(0, 1) != 0;
    mem_mem_r_en = $urandom_range(0, 2) == 0;
    wb_dest      = AW'($urandom_range(0, 7));
    wb_wb_en     = $urandom_range(0, 1) != 0;
    br_taken     = $urandom_range(0, 3) == 0;
    rst          = $urandom_range(0, 63) == 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    settle(); check_model();
    chk("rst_sel_a", sel_a, 2'b00);
    chk("rst_hold", ex_wb_hold, 1'b0);
    advance();
    rst = 1'b0;

    // Case 1: MEM forward, MEM beats WB
    mem_dest = 5'd3; mem_wb_en = 1'b1; ex_src1 = 5'd3;
    settle(); check_model(); chk("c1_mem_fwd", sel_a, 2'b01); advance();
    wb_dest = 5'd3; wb_wb_en = 1'b1;
    settle(); check_model(); chk("c1_mem_prio", sel_a, 2'b01); advance();
    mem_wb_en = 1'b0;
    settle(); check_model(); chk("c1_wb_fwd", sel_a, 2'b10); advance();

    // Case 2: register 0 never forwards nor stalls
    clear_inputs();
    mem_dest = 5'd0; mem_wb_en = 1'b1; ex_dest = 5'd0; ex_wb_en = 1'b1; ex_mem_r_en = 1'b1;
    ex_src1 = 5'd0; id_src1 = 5'd0;
    settle(); check_model();
    chk("c2_sel_a", sel_a, 2'b00); chk("c2_bubble", id_ex_bubble, 1'b0);
    advance();

    // Case 3: load-use stall, MEM_LAT=1 instance
    clear_inputs();
    ex_dest = 5'd5; ex_wb_en = 1'b1; ex_mem_r_en = 1'b1; id_src2 = 5'd5; id_use_src2 = 1'b1;
    settle(); check_model();
    chk("c3_bubble", id_ex_bubble_1, 1'b1); chk("c3_hold", if_id_hold_1, 1'b1);
    advance();
    ex_wb_en = 1'b0; ex_mem_r_en = 1'b0; mem_dest = 5'd5; mem_wb_en = 1'b1; mem_mem_r_en = 1'b1;
    settle(); check_model();
    chk("c3_bubble_rel", id_ex_bubble_1, 1'b0); chk("c3_hold_rel", if_id_hold_1, 1'b0);
    advance();
    clear_inputs();
    repeat (4) step();

    // Case 4: MEM_LAT=4 load with a branch waiting in EXE, from reset
    rst = 1'b1; step(); rst = 1'b0;
    mem_dest = 5'd9; mem_wb_en = 1'b1; mem_mem_r_en = 1'b1; br_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle(); check_model();
      chk("c4_hold", ex_wb_hold, (i < 3) ? 1'b1 : 1'b0);
      chk("c4_flush", flush, (i == 3) ? 1'b1 : 1'b0);
      advance();
    end
    clear_inputs();
    settle(); check_model();
`ifdef HAZARD_STAT_EN
    chk("c4_stat_hold", stat_hold, 3);
    chk("c4_stat_flush", stat_flush, 1);
`endif
    advance();

    // Case 5: forwarding off, stall through EXE and MEM, not WB
    clear_inputs();
    fwd_en = 1'b0; ex_dest = 5'd7; ex_wb_en = 1'b1; id_src1 = 5'd7; ex_src1 = 5'd7;
    settle(); check_model(); chk("c5_stall_ex", id_ex_bubble, 1'b1); advance();
    ex_wb_en = 1'b0; mem_dest = 5'd7; mem_wb_en = 1'b1;
    settle(); check_model();
    chk("c5_stall_mem", id_ex_bubble, 1'b1); chk("c5_sel_off", sel_a, 2'b00);
    advance();
    mem_wb_en = 1'b0; wb_dest = 5'd7; wb_wb_en = 1'b1;
    settle(); check_model();
    chk("c5_wb_nostall", if_id_hold, 1'b0); chk("c5_sel_wb_off", sel_a, 2'b00);
    advance();

    // Case 6: reset in the middle of a load wait
    clear_inputs();
    mem_mem_r_en = 1'b1; br_taken = 1'b1; ex_dest = 5'd4; ex_wb_en = 1'b1; ex_mem_r_en = 1'b1;
    id_src1 = 5'd4;
    step(); step();
    settle(); check_model(); chk("c6_pre_hold", ex_wb_hold, 1'b1);
    rst = 1'b1;
    #1;
    check_model();
    chk("c6_hold", ex_wb_hold, 1'b0); chk("c6_flush", flush, 1'b0);
    chk("c6_if_id", if_id_hold, 1'b0); chk("c6_state", dbg_state, RUN);
    chk("c6_stat_hold", stat_hold, 0);
    advance();
    rst = 1'b0;
    clear_inputs();
    step();

    // Random traffic
    repeat (400) begin
      drive_random();
      step();
    end
    rst = 1'b0;
    clear_inputs();
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
